// File: rtl/cordic_sequencer.sv
// Sequencer that feeds one sample at a time to a serial CORDIC engine and buffers
// its results in a two-entry FIFO. It also raises sticky timeout and mode-mismatch flags.
module cordic_sequencer #(
    parameter int TIMEOUT    = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_x,
    input  logic [15:0] s_y,
    input  logic [15:0] s_z,
    input  logic        s_mode,
    output logic [15:0] c_xi,
    output logic [15:0] c_yi,
    output logic [15:0] c_zi,
    output logic        c_mi,
    output logic        c_load,
    input  logic [15:0] c_xo,
    input  logic [15:0] c_yo,
    input  logic [15:0] c_zo,
    input  logic        c_mo,
    input  logic        c_rdy,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_x,
    output logic [15:0] m_y,
    output logic [15:0] m_z,
    output logic        m_mode,
    output logic        busy,
    output logic        timeout_err,
    output logic        mode_err,
    input  logic        clr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [1:0]  fifo_count_reg, fifo_count_next;
    logic [48:0] head_reg, head_next;
    logic [48:0] tail_reg, tail_next;
    logic [15:0] xi_reg, yi_reg, zi_reg;
    logic        mi_reg;
    logic        load_reg;
    logic        terr_reg, merr_reg;

    logic        accept;
    logic        push;
    logic        pop;
    logic        tset;
    logic        mset;
    logic [48:0] push_data;

    assign s_ready   = (state_reg == ST_IDLE) && (fifo_count_reg < 2'(FIFO_DEPTH));
    assign accept    = s_valid & s_ready;
    assign push      = (state_reg == ST_WAIT) & c_rdy;
    // A response in the final WAIT cycle beats the timeout.
    assign tset      = (state_reg == ST_WAIT) & ~c_rdy & (cnt_reg == 8'(TIMEOUT - 1));
    assign mset      = push & (c_mo != mi_reg);
    assign pop       = m_valid & m_ready;
    assign push_data = {c_xo, c_yo, c_zo, mi_reg};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT;
                cnt_next   = 8'd0;
            end
            ST_WAIT: begin
                if (c_rdy || tset) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The head register drives m_* directly, so it keeps its last value once drained.
    always_comb begin
        head_next       = head_reg;
        tail_next       = tail_reg;
        fifo_count_next = fifo_count_reg;
        if (push && pop) begin
            if (fifo_count_reg == 2'd1) begin
                head_next = push_data;
            end else begin
                head_next = tail_reg;
                tail_next = push_data;
            end
        end else if (push) begin
            if (fifo_count_reg == 2'd0) begin
                head_next = push_data;
            end else begin
                tail_next = push_data;
            end
            fifo_count_next = fifo_count_reg + 2'd1;
        end else if (pop) begin
            if (fifo_count_reg == 2'd2) begin
                head_next = tail_reg;
            end
            fifo_count_next = fifo_count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 8'd0;
            fifo_count_reg <= 2'd0;
            head_reg       <= '0;
            tail_reg       <= '0;
            xi_reg         <= 16'd0;
            yi_reg         <= 16'd0;
            zi_reg         <= 16'd0;
            mi_reg         <= 1'b0;
            load_reg       <= 1'b0;
            terr_reg       <= 1'b0;
            merr_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            fifo_count_reg <= fifo_count_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            load_reg       <= accept;
            if (accept) begin
                xi_reg <= s_x;
                yi_reg <= s_y;
                zi_reg <= s_z;
                mi_reg <= s_mode;
            end
            if (tset) begin
                terr_reg <= 1'b1;
            end else if (clr_err) begin
                terr_reg <= 1'b0;
            end
            if (mset) begin
                merr_reg <= 1'b1;
            end else if (clr_err) begin
                merr_reg <= 1'b0;
            end
        end
    end

    assign c_xi        = xi_reg;
    assign c_yi        = yi_reg;
    assign c_zi        = zi_reg;
    assign c_mi        = mi_reg;
    assign c_load      = load_reg;
    assign m_valid     = (fifo_count_reg != 2'd0);
    assign {m_x, m_y, m_z, m_mode} = head_reg;
    assign busy        = (state_reg == ST_LOAD) || (state_reg == ST_WAIT);
    assign timeout_err = terr_reg;
    assign mode_err    = merr_reg;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: a transaction-level model with an engine stand-in.
// It runs directed scenarios with literal checks, then randomized traffic.
module tb_cordic_sequencer;
    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0, s_mode = 1'b0;
    logic [15:0] s_x = '0, s_y = '0, s_z = '0;
    logic        s_ready;
    logic [15:0] c_xi, c_yi, c_zi;
    logic        c_mi, c_load;
    logic [15:0] c_xo = '0, c_yo = '0, c_zo = '0;
    logic        c_mo = 1'b0, c_rdy;
    logic        m_valid, m_ready = 1'b0;
    logic [15:0] m_x, m_y, m_z;
    logic        m_mode, busy, timeout_err, mode_err;
    logic        clr_err = 1'b0;

    cordic_sequencer #(.TIMEOUT(TIMEOUT), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_mode(s_mode),
        .c_xi(c_xi), .c_yi(c_yi), .c_zi(c_zi), .c_mi(c_mi), .c_load(c_load),
        .c_xo(c_xo), .c_yo(c_yo), .c_zo(c_zo), .c_mo(c_mo), .c_rdy(c_rdy),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_mode(m_mode),
        .busy(busy), .timeout_err(timeout_err), .mode_err(mode_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one sample in flight (age counts cycles since accept), plus a queue of results.
    bit          md_inflight = 1'b0;
    int          md_age      = 0;
    logic [48:0] md_q[$];
    logic [48:0] md_last     = '0;
    logic [15:0] op_x = '0, op_y = '0, op_z = '0;
    logic        op_m  = 1'b0;
    bit          tflag = 1'b0, mflag = 1'b0, acc_flag = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        bit          rdy_now, do_pop, do_push, tset, mset;
        logic [48:0] pd;
        if (!rst) begin
            md_inflight = 1'b0;
            md_age      = 0;
            md_q.delete();
            md_last     = '0;
            op_x = '0; op_y = '0; op_z = '0; op_m = 1'b0;
            tflag = 1'b0; mflag = 1'b0; acc_flag = 1'b0;
        end else begin
            rdy_now  = !md_inflight && (md_q.size() < 2);
            do_pop   = m_ready && (md_q.size() != 0);
            do_push  = 1'b0; tset = 1'b0; mset = 1'b0; pd = '0;
            acc_flag = 1'b0;
            if (md_inflight) begin
                if (md_age >= 2 && c_rdy) begin
                    do_push     = 1'b1;
                    pd          = {c_xo, c_yo, c_zo, op_m};
                    mset        = (c_mo !== op_m);
                    md_inflight = 1'b0;
                end else if (md_age - 1 == TIMEOUT) begin
                    tset        = 1'b1;
                    md_inflight = 1'b0;
                    $display("timeout x=%h y=%h z=%h mode=%b dropped", op_x, op_y, op_z, op_m);
                end else begin
                    md_age++;
                end
            end else if (s_valid && rdy_now) begin
                op_x = s_x; op_y = s_y; op_z = s_z; op_m = s_mode;
                md_inflight = 1'b1;
                md_age      = 1;
                acc_flag    = 1'b1;
            end
            if (do_pop) begin
                md_last = md_q.pop_front();
                $display("result x=%h y=%h z=%h mode=%b", md_last[48:33], md_last[32:17],
                         md_last[16:1], md_last[0]);
            end
            if (do_push) md_q.push_back(pd);
            tflag = tset ? 1'b1 : (clr_err ? 1'b0 : tflag);
            mflag = mset ? 1'b1 : (clr_err ? 1'b0 : mflag);
        end
    end

    always @(negedge clk) begin : compare
        logic [48:0] h;
        if (chk_en) begin
            h = (md_q.size() != 0) ? md_q[0] : md_last;
            chk1("s_ready", s_ready, !md_inflight && (md_q.size() < 2));
            chk1("busy", busy, md_inflight);
            chk1("c_load", c_load, md_inflight && md_age == 1);
            chk16("c_xi", c_xi, op_x);
            chk16("c_yi", c_yi, op_y);
            chk16("c_zi", c_zi, op_z);
            chk1("c_mi", c_mi, op_m);
            chk1("m_valid", m_valid, md_q.size() != 0);
            chk16("m_x", m_x, h[48:33]);
            chk16("m_y", m_y, h[32:17]);
            chk16("m_z", m_z, h[16:1]);
            chk1("m_mode", m_mode, h[0]);
            chk1("timeout_err", timeout_err, tflag);
            chk1("mode_err", mode_err, mflag);
        end
    end

    // Engine stand-in: responds eng_l cycles after c_load (-1 = never).
    int  eng_l = -1;
    bit  eng_fn = 1'b0, eng_flip = 1'b0, eng_rdy = 1'b0, rdy_force = 1'b0, rand_mode = 1'b0;
    int  dir_l = 5;
    bit  dir_fn = 1'b0, dir_flip = 1'b0;
    assign c_rdy = eng_rdy | rdy_force;

    always @(negedge clk) begin : engine
        int r;
        if (acc_flag) begin
            if (rand_mode) begin
                r        = int'($urandom_range(0, 15));
                eng_l    = (r == 0) ? -1 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 25));
                eng_fn   = 1'b1;
                eng_flip = ($urandom_range(0, 7) == 0);
            end else begin
                eng_l    = dir_l;
                eng_fn   = dir_fn;
                eng_flip = dir_flip;
            end
        end
        if (md_inflight && eng_l >= 0 && md_age == eng_l + 1) begin
            eng_rdy = 1'b1;
            c_xo    = eng_fn ? (op_x ^ 16'hA5A5) : op_x;
            c_yo    = eng_fn ? (op_y + 16'd7) : op_y;
            c_zo    = eng_fn ? ~op_z : op_z;
            c_mo    = eng_flip ? ~op_m : op_m;
        end else begin
            eng_rdy = rand_mode && (!md_inflight || md_age == 1) && ($urandom_range(0, 9) == 0);
            c_xo    = 16'($urandom);
            c_yo    = 16'($urandom);
            c_zo    = 16'($urandom);
            c_mo    = 1'($urandom);
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic md);
        s_valid = 1'b1; s_x = x; s_y = y; s_z = z; s_mode = md;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (acc_flag) break;
        end
        n_checks++;
        if (!acc_flag) begin
            n_fail++;
            $display("FAIL send_accept: got no accept expected accept for x=%h", x);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_m_valid", m_valid, 1'b0);

        // Single vector op, 22-cycle engine.
        m_ready = 1'b1; dir_l = 22; dir_fn = 1'b0; dir_flip = 1'b0;
        send(16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk1("d1_load", c_load, 1'b1);
        repeat (22) @(negedge clk);
        chk1("d1_pre_valid", m_valid, 1'b0);
        @(negedge clk);
        chk1("d1_valid", m_valid, 1'b1);
        chk16("d1_m_x", m_x, 16'h4000);
        chk16("d1_m_z", m_z, 16'h0000);
        chk1("d1_m_mode", m_mode, 1'b0);
        @(negedge clk);

        // Backpressure: two results fill the FIFO, third sample waits for a pop.
        m_ready = 1'b0; dir_l = 3; dir_fn = 1'b1;
        send(16'h1111, 16'h0002, 16'h0003, 1'b0);
        repeat (6) @(negedge clk);
        send(16'h0101, 16'h0004, 16'h0005, 1'b1);
        repeat (6) @(negedge clk);
        chk1("d2_full_ready", s_ready, 1'b0);
        chk16("d2_head", m_x, 16'hB4B4);
        s_valid = 1'b1; s_x = 16'h2222; s_y = 16'h0006; s_z = 16'h0007; s_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk1("d2_stalled", busy, 1'b0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk16("d2_second", m_x, 16'hA4A4);
        for (int n = 0; n < 10 && !acc_flag; n++) @(negedge clk);
        s_valid = 1'b0;
        chk1("d2_third_acc", acc_flag, 1'b1);
        repeat (6) @(negedge clk);
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk1("d2_drained", m_valid, 1'b0);
        chk16("d2_hold", m_x, 16'h8787);

        // Timeout: engine never answers.
        dir_l = -1;
        send(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0);
        repeat (32) @(negedge clk);
        chk1("d3_pre_terr", timeout_err, 1'b0);
        @(negedge clk);
        chk1("d3_terr", timeout_err, 1'b1);
        chk1("d3_idle", busy, 1'b0);
        chk1("d3_no_valid", m_valid, 1'b0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk1("d3_clr", timeout_err, 1'b0);

        // Mode mismatch: result still delivered with the issued mode.
        m_ready = 1'b0; dir_l = 5; dir_fn = 1'b0; dir_flip = 1'b1;
        send(16'h0123, 16'h0456, 16'h0789, 1'b1);
        repeat (6) @(negedge clk);
        chk1("d4_merr", mode_err, 1'b1);
        chk1("d4_valid", m_valid, 1'b1);
        chk1("d4_m_mode", m_mode, 1'b1);
        chk16("d4_m_x", m_x, 16'h0123);
        m_ready = 1'b1; clr_err = 1'b1; dir_flip = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
        chk1("d4_clr", mode_err, 1'b0);

        // Reset during WAIT, late engine response after release.
        dir_l = 10;
        send(16'h7777, 16'h1234, 16'h4321, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk); #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        rdy_force = 1'b1;
        @(negedge clk);
        rdy_force = 1'b0;
        @(negedge clk);
        chk1("d5_m_valid", m_valid, 1'b0);
        chk1("d5_busy", busy, 1'b0);
        chk1("d5_s_ready", s_ready, 1'b1);
        chk16("d5_c_xi", c_xi, 16'h0000);
        chk16("d5_m_x", m_x, 16'h0000);

        // c_rdy on the last WAIT cycle together with a pop at count 1.
        m_ready = 1'b0; dir_l = 3; dir_fn = 1'b1;
        send(16'h000F, 16'h0001, 16'h0001, 1'b0);
        repeat (6) @(negedge clk);
        chk16("d6_first", m_x, 16'hA5AA);
        dir_l = TIMEOUT;
        send(16'h00F0, 16'h0002, 16'h0002, 1'b1);
        repeat (32) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk1("d6_no_terr", timeout_err, 1'b0);
        chk1("d6_valid", m_valid, 1'b1);
        chk16("d6_m_x", m_x, 16'hA555);
        chk1("d6_idle", busy, 1'b0);
        @(negedge clk);
        chk1("d6_count1", m_valid, 1'b1);
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk1("d6_empty", m_valid, 1'b0);

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, 1) == 1);
            s_x     = 16'($urandom);
            s_y     = 16'($urandom);
            s_z     = 16'($urandom);
            s_mode  = 1'($urandom);
            m_ready = ($urandom_range(0, 9) < 7);
            clr_err = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        s_valid = 1'b0; clr_err = 1'b0; m_ready = 1'b1;
        repeat (80) @(negedge clk);
        chk1("final_empty", m_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
